pe_net_iface: RTL

PE_NET_IFACE -- requirements
Module: pe_net_iface

---
 rtl/pe_net_iface_pkg.sv | 37 +++
 rtl/pe_net_iface_sync_fifo.sv | 62 ++++++
 rtl/pe_net_iface.sv | 118 +++++++++++
 3 files changed

// File: rtl/pe_net_iface_pkg.sv
// Packet format shared between the PE network interface and the router side.
// Field positions and type codes for 32-bit NoC packets.
package pe_net_iface_pkg;

    typedef enum logic [1:0] {
        PKT_FILTER = 2'b00,
        PKT_IFMAP  = 2'b01,
        PKT_PSUM   = 2'b10
    } pkt_type_e;

    localparam int unsigned PKT_W      = 32;
    localparam int unsigned PAYLOAD_W  = 13;

    localparam int unsigned RSVD_BIT   = 31;
    localparam int unsigned TYPE_HI    = 30;
    localparam int unsigned TYPE_LO    = 29;
    localparam int unsigned DSTY_HI    = 28;
    localparam int unsigned DSTY_LO    = 24;
    localparam int unsigned DSTX_HI    = 23;
    localparam int unsigned DSTX_LO    = 21;
    localparam int unsigned SRC_HI     = 20;
    localparam int unsigned SRC_LO     = 13;
    localparam int unsigned PAYLOAD_HI = 12;
    localparam int unsigned PAYLOAD_LO = 0;

    function automatic logic [PKT_W-1:0] make_pkt(
        input pkt_type_e              pkt_type,
        input logic [4:0]             dst_y,
        input logic [2:0]             dst_x,
        input logic [4:0]             src_y,
        input logic [2:0]             src_x,
        input logic [PAYLOAD_W-1:0]   payload
    );
        return {1'b0, pkt_type, dst_y, dst_x, src_y, src_x, payload};
    endfunction

endpackage

// File: rtl/pe_net_iface_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two so
// the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = valid_o && ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/pe_net_iface.sv
// PE-side network interface: sorts incoming filter/ifmap packets into FIFOs,
// counts discarded packets, and wraps PE partial sums into outgoing packets.
module pe_net_iface
    import pe_net_iface_pkg::*;
#(
    parameter int unsigned WIDTH_PKT = 32,
    parameter logic [2:0]  ADDRX     = 3'd0,
    parameter logic [4:0]  ADDRY     = 5'd0,
    parameter logic [2:0]  DSTX      = 3'd0,
    parameter logic [4:0]  DSTY      = 5'd0,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [WIDTH_PKT-1:0] rx_pkt,
    output logic                 rx_ready,
    output logic                 filt_valid,
    output logic [12:0]          filt_data,
    input  logic                 filt_ready,
    output logic                 ifm_valid,
    output logic [12:0]          ifm_data,
    input  logic                 ifm_ready,
    input  logic                 psum_valid,
    input  logic [12:0]          psum_data,
    output logic                 psum_ready,
    output logic                 tx_valid,
    output logic [WIDTH_PKT-1:0] tx_pkt,
    input  logic                 tx_ready,
    output logic [7:0]           drop_cnt
);

    logic [1:0]           rx_type;
    logic                 own_dst;
    logic                 rx_accept;
    logic                 filt_push, ifm_push, drop;
    logic                 filt_full, ifm_full;
    logic [PAYLOAD_W-1:0] rx_payload;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [WIDTH_PKT-1:0] tx_pkt_q, tx_pkt_d;
    logic                 psum_accept;
    logic                 unused_rx_bits;

    assign rx_type    = rx_pkt[TYPE_HI:TYPE_LO];
    assign rx_payload = rx_pkt[PAYLOAD_HI:PAYLOAD_LO];
    assign own_dst    = (rx_pkt[DSTY_HI:DSTY_LO] == ADDRY) && (rx_pkt[DSTX_HI:DSTX_LO] == ADDRX);
    assign unused_rx_bits = ^{rx_pkt[RSVD_BIT], rx_pkt[SRC_HI:SRC_LO]};

    // Both FIFOs gate acceptance so rx_ready never depends on the packet itself.
    assign rx_ready  = !filt_full && !ifm_full;
    assign rx_accept = rx_valid && rx_ready;
    assign filt_push = rx_accept && own_dst && (rx_type == PKT_FILTER);
    assign ifm_push  = rx_accept && own_dst && (rx_type == PKT_IFMAP);
    assign drop      = rx_accept && !filt_push && !ifm_push;

    sync_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (DEPTH)
    ) u_filt_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (filt_push),
        .push_data_i (rx_payload),
        .full_o      (filt_full),
        .valid_o     (filt_valid),
        .data_o      (filt_data),
        .ready_i     (filt_ready)
    );

    sync_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (DEPTH)
    ) u_ifm_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (ifm_push),
        .push_data_i (rx_payload),
        .full_o      (ifm_full),
        .valid_o     (ifm_valid),
        .data_o      (ifm_data),
        .ready_i     (ifm_ready)
    );

    assign psum_ready  = !tx_valid_q || tx_ready;
    assign psum_accept = psum_valid && psum_ready;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;

        tx_valid_d = tx_valid_q;
        tx_pkt_d   = tx_pkt_q;
        if (psum_accept) begin
            tx_valid_d = 1'b1;
            tx_pkt_d   = WIDTH_PKT'(make_pkt(PKT_PSUM, DSTY, DSTX, ADDRY, ADDRX, psum_data));
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
            tx_valid_q <= 1'b0;
            tx_pkt_q   <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_pkt_q   <= tx_pkt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign tx_valid = tx_valid_q;
    assign tx_pkt   = tx_pkt_q;

endmodule
